// File: rtl/fetch_queue_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_stage_if
// Purpose  : Bundles the instruction-memory port, the execute redirect and the
//            decode handshake of the fetch queue stage.
// Ports    : master - fetch stage side (drives memory request and decode head)
//            slave  - environment side (memory, execute and decode)
//            memory_inst_start/_ready, memory_i_addr, memory_inst/_valid
//            redirect_valid, redirect_pc
//            id_valid, id_ready, id_reg_pc, id_inst, queue_count
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_queue_stage_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     memory_inst_start;
  logic                     memory_inst_ready;
  logic [XLEN-1:0]          memory_i_addr;
  logic [XLEN-1:0]          memory_inst;
  logic                     memory_inst_valid;
  logic                     redirect_valid;
  logic [XLEN-1:0]          redirect_pc;
  logic                     id_valid;
  logic                     id_ready;
  logic [XLEN-1:0]          id_reg_pc;
  logic [XLEN-1:0]          id_inst;
  logic [$clog2(DEPTH):0]   queue_count;

  modport master (
    output memory_inst_start, memory_i_addr, id_valid, id_reg_pc, id_inst,
           queue_count,
    input  memory_inst_ready, memory_inst, memory_inst_valid, redirect_valid,
           redirect_pc, id_ready
  );

  modport slave (
    input  memory_inst_start, memory_i_addr, id_valid, id_reg_pc, id_inst,
           queue_count,
    output memory_inst_ready, memory_inst, memory_inst_valid, redirect_valid,
           redirect_pc, id_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_stage
// Purpose  : Issues one instruction fetch at a time, buffers responses in a
//            DEPTH-entry FIFO of {pc, inst} and presents the head to decode
//            with valid/ready. A redirect flushes the queue and discards any
//            in-flight response.
// Ports    : clk   - clock, rising edge
//            reset - synchronous active-high reset
//            bus   - fetch_queue_stage_if.master (memory, redirect, decode)
// Options  : FETCH_BYPASS_EN - when defined, a response arriving to an empty
//            queue is offered to decode in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_stage #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fetch_queue_stage_if.master bus
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_WAIT    = 2'd1;
  localparam logic [1:0] c_ST_DISCARD = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_CW-1:0] r_count;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW-1:0] r_wr_ptr;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [XLEN-1:0] r_inst_mem [DEPTH];

  logic w_issue;
  logic w_resp;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_issue) w_state_nxt = c_ST_WAIT;
      end
      c_ST_WAIT: begin
        // A response always closes the request; only a redirect with the
        // response still outstanding leaves us waiting for data to drop.
        if (bus.memory_inst_valid)    w_state_nxt = c_ST_IDLE;
        else if (bus.redirect_valid)  w_state_nxt = c_ST_DISCARD;
      end
      c_ST_DISCARD: begin
        if (bus.memory_inst_valid) w_state_nxt = c_ST_IDLE;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_issue = 1'b0;
    w_resp  = 1'b0;
    case (r_state)
      c_ST_IDLE: w_issue = bus.memory_inst_ready && (r_count < c_FULL) &&
                           !bus.redirect_valid && !reset;
      c_ST_WAIT: w_resp  = bus.memory_inst_valid;
      default: begin
        w_issue = 1'b0;
        w_resp  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- bypass
`ifdef FETCH_BYPASS_EN
  assign w_bypass = (r_count == '0) && w_resp && !bus.redirect_valid && !reset;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed response that decode takes immediately never enters the FIFO.
  assign w_push = w_resp && !bus.redirect_valid && !(w_bypass && bus.id_ready);
  assign w_pop  = (r_count != '0) && bus.id_ready && !bus.redirect_valid;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]   <= r_req_pc;
        r_inst_mem[r_wr_ptr] <= bus.memory_inst;
        r_wr_ptr             <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      // Issue only below DEPTH reserves the slot, so push never overflows.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_issue) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.memory_inst_start = w_issue;
  assign bus.memory_i_addr     = r_fetch_pc;
  assign bus.queue_count       = r_count;
  assign bus.id_valid          = (r_count != '0) || w_bypass;
  assign bus.id_reg_pc         = w_bypass ? r_req_pc        : r_pc_mem[r_rd_ptr];
  assign bus.id_inst           = w_bypass ? bus.memory_inst : r_inst_mem[r_rd_ptr];

endmodule
`default_nettype wire
